// File: rtl/prod_accum.sv
// prod_accum: sums groups of N unsigned products taken over a valid/ready
// handshake and holds each finished group sum until downstream takes it.
// A flush closes a partial group early; an empty group never produces a result.
//
// state | meaning
// ------+-----------------------------------------------------------------
// ACC   | accepting products, acc/idx hold the running partial group
// HOLD  | sum/cnt presented with out_valid=1, input stalled until out_ready

module prod_accum #(
   parameter int PW = 6,
   parameter int N  = 4,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] prod,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] sum,
   output logic [4:0]    cnt
);

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [4:0] LAST = 5'(N - 1);

   state_t        state;
   logic [AW-1:0] acc;
   logic [4:0]    idx;
   logic [AW-1:0] prod_ext;

   assign prod_ext = AW'(prod);

   // Input is accepted only while accumulating; no dependence on in_valid.
   assign in_ready = (state == ACC);

   // Group accumulation, group close (full, flush, or flush with product) and output hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACC;
         acc       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         sum       <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            ACC: begin
               if (in_valid) begin
                  if (flush || (idx == LAST)) begin
                     sum       <= acc + prod_ext;
                     cnt       <= idx + 5'd1;
                     acc       <= '0;
                     idx       <= '0;
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     acc <= acc + prod_ext;
                     idx <= idx + 5'd1;
                  end
               end else if (flush && (idx != 5'd0)) begin
                  sum       <= acc;
                  cnt       <= idx;
                  acc       <= '0;
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ACC;
               end
            end
            default: begin
               state     <= ACC;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream consumer of the 3x3 array multiplier stage.
- Accepts 6-bit unsigned products over a valid/ready handshake and sums N consecutive products (a dot product of N operand pairs).
- Presents each completed sum on a held output handshake.
- A flush input closes a partial group early.

Parameters:
PW, 6, product input width (unsigned).
N, 4, products per group; legal range 2..16.
AW, 8, sum width; must be >= PW + clog2(N). The default gives a maximum sum of 4*49 = 196, so it cannot overflow.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  prod is valid this cycle
in_ready  output  1  block can accept a product this cycle
prod  input  PW  unsigned product from the multiplier stage
flush  input  1  close the current group early (level-sampled, single-cycle pulse expected)
out_valid  output  1  sum is valid and held
out_ready  input  1  downstream accepts sum this cycle
sum  output  AW  accumulated group sum
cnt  output  5  number of products included in sum (valid with out_valid)

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state:
  - state=ACC; internal acc=0, idx=0.
  - out_valid=0, sum=0, cnt=0.
  - in_ready=1 from the first cycle after reset.
  - A reset mid-group or mid-HOLD discards all partial and pending data.
- Transfer definitions:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- State ACC:
  - in_ready=1, out_valid=0.
  - On an input transfer with idx < N-1: acc <= acc + prod; idx <= idx+1.
  - On an input transfer with idx == N-1: sum <= acc + prod; cnt <= N; acc <= 0; idx <= 0; go to HOLD.
  - flush=1 with no input transfer and idx > 0: sum <= acc; cnt <= idx; acc <= 0; idx <= 0; go to HOLD.
  - flush=1 with no input transfer and idx == 0: ignored; no empty result is ever emitted.
  - flush=1 together with an input transfer: the product is included; sum <= acc + prod; cnt <= idx+1; go to HOLD. This also covers idx == N-1, which yields cnt=N.
- State HOLD:
  - out_valid=1, in_ready=0.
  - sum and cnt are held stable until the output transfer.
  - flush and prod are ignored.
  - On an output transfer: out_valid <= 0; go to ACC. in_ready is 1 in the following cycle.
  - There is no same-cycle output-to-input bypass; at most one group completes every N+1 cycles.
- Latency: sum is visible (out_valid=1) in the cycle after the edge that accepts the last product or the flush.
- Arithmetic:
  - Unsigned, zero-extended from PW to AW.
  - Wrap modulo 2^AW if the parameters are misconfigured; no saturation.
- in_ready is a pure function of state (combinational, no dependence on in_valid).
- out_valid, sum and cnt are registered.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset, then a full group: products 49, 49, 49, 49 with in_valid held high. Required: out_valid rises 1 cycle after the 4th accept, sum=196, cnt=4; in_ready=0 until out_ready is asserted.
- Backpressure: group 1, 2, 3, 4 completes and out_ready is held 0 for 5 cycles. Required: sum=10 and cnt=4 stable throughout, in_ready=0; after the out_ready pulse, out_valid=0 and in_ready=1 the next cycle.
- Partial flush: accept 7 then 5, then flush alone. Required: sum=12, cnt=2. A flush with idx=0 must produce no out_valid.
- Simultaneous flush and input: accept 3, then prod=6 with flush in the same cycle. Required: sum=9, cnt=2. Repeat at idx=N-1 with products 1, 1, 1 + (2 with flush). Required: sum=5, cnt=4.
- Reset mid-operation:
  - Assert rst after 2 accepted products. Required: out_valid=0; the next full group 2, 2, 2, 2 gives sum=8.
  - Assert rst during HOLD. Required: out_valid drops next cycle, sum=0.
- Gapped input: in_valid toggles 1, 0, 1, 0 with products 10, 20, 30, 40 on the valid cycles. Required: sum=100, cnt=4; idle cycles do not advance idx.
